muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits downstream of the register file read ports, in parallel with the ALU.
- Consumes rs/rt operands and produces HI/LO values that the writeback mux reads for mfhi/mflo.
- Supports multu/mult/divu/div, plus mthi/mtlo writes. Uses a start/busy/done handshake so the controller can stall.

---
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_SIGNED_EN to build signed mult/div (op[0]=1).
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   ma_q, ma_d;
    logic [XLEN-1:0]   mb_q, mb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] res;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;
    logic              ge;
    logic [XLEN-1:0]   rem_new;

`ifdef MULDIV_SIGNED_EN
    logic sa, sb;
    logic pneg_q, pneg_d;
    logic rneg_q, rneg_d;

    assign sa    = op[0] & a[XLEN-1];
    assign sb    = op[0] & b[XLEN-1];
    assign a_mag = sa ? (~a + 1'b1) : a;
    assign b_mag = sb ? (~b + 1'b1) : b;

    // Divide-by-zero keeps the all-ones quotient un-negated.
    always_comb begin
        pneg_d = pneg_q;
        rneg_d = rneg_q;
        if (state_q == IDLE && start) begin
            pneg_d = (sa ^ sb) & ~(op[1] & (b == '0));
            rneg_d = sa;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            pneg_q <= pneg_d;
            rneg_q <= rneg_d;
        end
    end

    always_comb begin
        res = acc_q;
        if (!is_div_q) begin
            if (pneg_q) res = ~acc_q + 1'b1;
        end else begin
            if (pneg_q) res[XLEN-1:0] = ~acc_q[XLEN-1:0] + 1'b1;
            if (rneg_q) res[2*XLEN-1:XLEN] = ~acc_q[2*XLEN-1:XLEN] + 1'b1;
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign a_mag      = a;
    assign b_mag      = b;
    assign res        = acc_q;
`endif

    // Multiply: right-shifting accumulator, multiplier bits consumed LSB first.
    assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mb_q[0] ? ma_q : '0)};

    // Divide: remainder in the upper half, quotient bits shift into the lower half.
    assign rem_sh  = {acc_q[2*XLEN-1:XLEN], ma_q[XLEN-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, mb_q};
    assign ge      = ~diff[XLEN+1];
    assign rem_new = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    is_div_d = op[1];
                    ma_d     = a_mag;
                    mb_d     = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_d = {rem_new, acc_q[XLEN-2:0], ge};
                    ma_d  = ma_q << 1;
                end else begin
                    acc_d = {sum, acc_q[XLEN-1:1]};
                    mb_d  = mb_q >> 1;
                end
                if (cnt_q == CNTW'(XLEN - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                hi_d    = res[2*XLEN-1:XLEN];
                lo_d    = res[XLEN-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        bit     s;
        longint sx, sy, q, m;
        logic [63:0] r;
        s  = SGN && o[0];
        sx = s ? longint'($signed(x)) : longint'({32'b0, x});
        sy = s ? longint'($signed(y)) : longint'({32'b0, y});
        if (!o[1]) begin
            r = 64'(sx * sy);
        end else if (y == 32'h0) begin
            r = {x, 32'hFFFFFFFF};
        end else if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            r = {32'h0, 32'h80000000};
        end else begin
            q = sx / sy;
            m = sx % sy;
            r = {32'(m), 32'(q)};
        end
        return r;
    endfunction

    // mode 0 plain, 1 start+mtlo while busy, 2 mthi on FIX edge, 3 mtlo with start
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int mode, input bit b2b, output logic [63:0] res);
        int          lat;
        int          bc;
        logic [31:0] lo_prev;
        logic [63:0] exp;
        exp = model(o, x, y);
        if (!b2b) @(negedge clk);
        lo_prev = lo;
        start   = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        if (mode == 3) begin
            lo_we = 1'b1;
            wd    = 32'h5555;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        chk("e0_busy", 64'(busy), 64'(1));
        chk("e0_done", 64'(done), 64'(0));
        chk("e0_lo_hold", 64'(lo), 64'(lo_prev));
        lat = 0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            if (mode == 1) begin
                start = (lat == 10);
                lo_we = (lat == 12);
                wd    = 32'hDEAD;
            end
            if (mode == 2) begin
                hi_we = (lat == 32);
                wd    = 32'hBEEF;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        lo_we = 1'b0;
        hi_we = 1'b0;
        chk("latency", 64'(lat), 64'(33));
        chk("busy_cycles", 64'(bc), 64'(33));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("result", {hi, lo}, exp);
        res = {hi, lo};
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] hp;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          n;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        wd    = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        #2;
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        reset = 1'b0;

        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, r);
        chk("multu_max", r, 64'hFFFFFFFE_00000001);
        do_op(2'b01, 32'hFFFFFFFD, 32'd5, 3, 1'b0, r);
        chk("mult_neg", r, SGN ? 64'hFFFFFFFF_FFFFFFF1 : 64'h00000004_FFFFFFF1);
        do_op(2'b10, 32'd100, 32'd7, 0, 1'b0, r);
        chk("divu_100_7", r, {32'd2, 32'd14});
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 1'b1, r);
        chk("div_neg7_2", r, SGN ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC);
        do_op(2'b10, 32'd123, 32'd0, 0, 1'b1, r);
        chk("divu_by0", r, {32'd123, 32'hFFFFFFFF});
        do_op(2'b11, 32'hFFFFFFF9, 32'd0, 0, 1'b0, r);
        chk("div_by0_neg", r, {32'hFFFFFFF9, 32'hFFFFFFFF});
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, r);
        chk("div_ovf", r, SGN ? {32'h0, 32'h80000000} : {32'h80000000, 32'h0});
        do_op(2'b00, 32'd12345, 32'd6789, 1, 1'b0, r);
        chk("busy_ignore", r, 64'd83810205);
        do_op(2'b10, 32'd1000, 32'd33, 2, 1'b0, r);
        chk("fix_edge_mthi", r, {32'd10, 32'd30});

        @(negedge clk);
        hp    = hi;
        lo_we = 1'b1;
        wd    = 32'h1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        chk("mtlo", {hi, lo}, {hp, 32'h1234});
        @(negedge clk);
        hi_we = 1'b1;
        wd    = 32'hCAFE;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        chk("mthi", {hi, lo}, {32'hCAFE, 32'h1234});

        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h0F0F0F0F;
        b     = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy_done", 64'({busy, done}), 64'(0));
        chk("midrst_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n++;
        end
        chk("no_done_after_rst", 64'(n), 64'(0));
        do_op(2'b00, 32'd7, 32'd9, 0, 1'b0, r);
        chk("post_rst_op", r, 64'd63);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            case ($urandom_range(0, 5))
                0:       rx = 32'h0;
                1:       rx = 32'h80000000;
                2:       rx = 32'hFFFFFFFF;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       ry = 32'h0;
                1:       ry = 32'hFFFFFFFF;
                2:       ry = 32'($urandom_range(1, 255));
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry, 0, 1'($urandom_range(0, 1)), r);
        end
        @(posedge clk);
        #1;
        chk("done_drop", 64'(done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
